// File: rtl/lib_switchblock_pkg.sv
// Shared constants and state encoding for the DEM tree switching-block scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lib_switchblock_pkg;

    localparam int SB_DATA_W     = 16;
    localparam int SB_NUM_LAYERS = 3;
    localparam int SB_NUM_NODES  = (1 << SB_NUM_LAYERS) - 1;
    localparam int SB_NUM_LEAVES = 1 << SB_NUM_LAYERS;
    localparam int SB_PTR_W      = SB_NUM_LAYERS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/dem_node_buffer.sv
// Heap-indexed register file holding every node and leaf value of the DEM tree.
// Latency: writes land on the next rising edge; read port and leaf bus are combinational.
// Backpressure: none; the scheduler decides when writes happen.
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset (clears all entries)
//   root_we_i/root_dat_i   write entry 1 (tree root)
//   pair_we_i/pair_idx_i   write entries 2n and 2n+1 with child1_i/child2_i
//   rd_idx_i/rd_dat_o      single combinational read port
//   leaves_o               leaf j = entry 2^NUM_LAYERS + j at bits [j*DATA_W +: DATA_W]
module dem_node_buffer #(
    parameter int DATA_W     = 16,
    parameter int NUM_LAYERS = 3
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 root_we_i,
    input  logic [DATA_W-1:0]                    root_dat_i,
    input  logic                                 pair_we_i,
    input  logic [NUM_LAYERS-1:0]                pair_idx_i,
    input  logic [DATA_W-1:0]                    child1_i,
    input  logic [DATA_W-1:0]                    child2_i,
    input  logic [NUM_LAYERS:0]                  rd_idx_i,
    output logic [DATA_W-1:0]                    rd_dat_o,
    output logic [(1<<NUM_LAYERS)*DATA_W-1:0]    leaves_o
);

    localparam int IDX_W      = NUM_LAYERS + 1;
    localparam int DEPTH      = 1 << IDX_W;
    localparam int NUM_LEAVES = 1 << NUM_LAYERS;
    localparam logic [IDX_W-1:0] ROOT_IDX = IDX_W'(1);

    // Entry 0 is never addressed; keeping it lets heap indices map directly.
    logic [DATA_W-1:0] mem [DEPTH];

    // Internal node pointers never exceed 2^NUM_LAYERS-1, so dropping the
    // pointer's MSB before the shift loses nothing.
    logic [IDX_W-1:0] left_idx;
    logic [IDX_W-1:0] right_idx;

    assign left_idx  = {pair_idx_i, 1'b0};
    assign right_idx = {pair_idx_i, 1'b1};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (root_we_i) begin
                mem[ROOT_IDX] <= root_dat_i;
            end
            if (pair_we_i) begin
                mem[left_idx]  <= child1_i;
                mem[right_idx] <= child2_i;
            end
        end
    end

    assign rd_dat_o = mem[rd_idx_i];

    for (genvar j = 0; j < NUM_LEAVES; j++) begin : g_leaf
        assign leaves_o[j*DATA_W +: DATA_W] = mem[IDX_W'(NUM_LEAVES + j)];
    end

endmodule

// File: rtl/dem_tree_scheduler.sv
// Walks a binary DEM tree in heap order through one shared switching block, then presents the leaves.
// Latency: out_valid_o 2*(2^NUM_LAYERS-1)+1 cycles after input handshake with a zero-stall, 1-cycle switch.
// Backpressure: in_ready_o only in IDLE; sw request held until sw_ready_i; leaf vector held until out_ready_i.
//
// Ports:
//   clk_i, reset_i                       clock, synchronous active-high reset
//   in_data_i/in_valid_i/in_ready_o      sample input handshake
//   sw_x_o/sw_layer_o/sw_valid_o/sw_ready_i   node request to switching block
//   sw_rsp_valid_i/sw_x1_i/sw_x2_i       single-cycle child response
//   out_leaves_o/out_valid_o/out_ready_i leaf vector output handshake
//   err_o                                sticky flag: response arrived outside WAIT
module dem_tree_scheduler
    import lib_switchblock_pkg::*;
#(
    parameter int DATA_W     = SB_DATA_W,
    parameter int NUM_LAYERS = SB_NUM_LAYERS
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [DATA_W-1:0]                    in_data_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    output logic [DATA_W-1:0]                    sw_x_o,
    output logic [$clog2(NUM_LAYERS)-1:0]        sw_layer_o,
    output logic                                 sw_valid_o,
    input  logic                                 sw_ready_i,
    input  logic                                 sw_rsp_valid_i,
    input  logic [DATA_W-1:0]                    sw_x1_i,
    input  logic [DATA_W-1:0]                    sw_x2_i,
    output logic [(1<<NUM_LAYERS)*DATA_W-1:0]    out_leaves_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic                                 err_o
);

    localparam int PTR_W   = NUM_LAYERS + 1;
    localparam int LAYER_W = $clog2(NUM_LAYERS);
    localparam logic [PTR_W-1:0] FIRST_NODE = PTR_W'(1);
    localparam logic [PTR_W-1:0] LAST_NODE  = PTR_W'((1 << NUM_LAYERS) - 1);

    sched_state_t     state, state_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic             root_we;
    logic             pair_we;
    logic             err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= S_IDLE;
            ptr   <= FIRST_NODE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            // A response with nothing outstanding is dropped, but remembered.
            if (sw_rsp_valid_i && (state != S_WAIT)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        in_ready_o = 1'b0;
        sw_valid_o = 1'b0;
        out_valid_o = 1'b0;
        root_we    = 1'b0;
        pair_we    = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    root_we   = 1'b1;
                    ptr_nxt   = FIRST_NODE;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sw_valid_o = 1'b1;
                if (sw_ready_i) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sw_rsp_valid_i) begin
                    pair_we = 1'b1;
                    if (ptr == LAST_NODE) begin
                        state_nxt = S_DONE;
                    end else begin
                        ptr_nxt   = ptr + PTR_W'(1);
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Layer of a heap node is the position of its leading one (root = 1 -> layer 0).
    always_comb begin
        sw_layer_o = '0;
        for (int b = 1; b < PTR_W; b++) begin
            if (ptr[b]) begin
                sw_layer_o = LAYER_W'(b);
            end
        end
    end

    dem_node_buffer #(
        .DATA_W     (DATA_W),
        .NUM_LAYERS (NUM_LAYERS)
    ) u_node_buffer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .root_we_i  (root_we),
        .root_dat_i (in_data_i),
        .pair_we_i  (pair_we),
        .pair_idx_i (ptr[PTR_W-2:0]),
        .child1_i   (sw_x1_i),
        .child2_i   (sw_x2_i),
        .rd_idx_i   (ptr),
        .rd_dat_o   (sw_x_o),
        .leaves_o   (out_leaves_o)
    );

    assign err_o = err_q;

endmodule
